// File: rtl/udp_tx_channel_arbiter_if.sv
// rtl/udp_tx_channel_arbiter_if.sv - multi-lane UDP metadata plus data stream bundle
interface udp_tx_channel_arbiter_if #(
   parameter int LANES          = 1,
   parameter int DATA_WIDTH     = 256,
   parameter int KEEP_WIDTH     = 32,
   parameter int IP_ADDR_WIDTH  = 32,
   parameter int UDP_PORT_WIDTH = 16,
   parameter int UDP_LEN_WIDTH  = 16
);
   logic [LANES-1:0]                meta_valid;
   logic [LANES-1:0]                meta_ready;
   logic [LANES*IP_ADDR_WIDTH-1:0]  meta_ip_addr;
   logic [LANES*UDP_PORT_WIDTH-1:0] meta_dst_port;
   logic [LANES*UDP_PORT_WIDTH-1:0] meta_src_port;
   logic [LANES*UDP_LEN_WIDTH-1:0]  meta_data_len;
   logic [LANES-1:0]                tvalid;
   logic [LANES-1:0]                tready;
   logic [LANES-1:0]                tfirst;
   logic [LANES-1:0]                tlast;
   logic [LANES*DATA_WIDTH-1:0]     tdata;
   logic [LANES*KEEP_WIDTH-1:0]     tkeep;

   modport master (
      output meta_valid, meta_ip_addr, meta_dst_port, meta_src_port, meta_data_len,
      output tvalid, tfirst, tlast, tdata, tkeep,
      input  meta_ready, tready
   );

   modport slave (
      input  meta_valid, meta_ip_addr, meta_dst_port, meta_src_port, meta_data_len,
      input  tvalid, tfirst, tlast, tdata, tkeep,
      output meta_ready, tready
   );
endinterface

// File: rtl/udp_tx_channel_arbiter.sv
// rtl/udp_tx_channel_arbiter.sv - round-robin merge of N UDP TX client channels
module udp_tx_channel_arbiter #(
   parameter int NUM_CHANNELS   = 4,
   parameter int DATA_WIDTH     = 256,
   parameter int KEEP_WIDTH     = 32,
   parameter int IP_ADDR_WIDTH  = 32,
   parameter int UDP_PORT_WIDTH = 16,
   parameter int UDP_LEN_WIDTH  = 16,
   localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
   input  logic                    clk,
   input  logic                    reset_n,
   udp_tx_channel_arbiter_if.slave  s_if,
   udp_tx_channel_arbiter_if.master m_if,
   output logic [CW-1:0]           m_grant_chan,
   output logic                    busy,
   output logic [NUM_CHANNELS-1:0] err_framing
);
   localparam int N = NUM_CHANNELS;

   typedef enum logic [1:0] {ST_IDLE, ST_META, ST_DATA} state_t;

   state_t                    state_q, state_d;
   logic [CW-1:0]             rr_q, rr_d;
   logic [CW-1:0]             grant_q, grant_d;
   logic [IP_ADDR_WIDTH-1:0]  ip_q, ip_d;
   logic [UDP_PORT_WIDTH-1:0] dst_q, dst_d;
   logic [UDP_PORT_WIDTH-1:0] src_q, src_d;
   logic [UDP_LEN_WIDTH-1:0]  len_q, len_d;
   logic                      first_q, first_d;
   logic [N-1:0]              err_q, err_d;

   logic [N-1:0]              meta_ready;
   logic [N-1:0]              data_ready;
   logic                      out_meta_valid;
   logic                      out_tvalid;
   logic                      beat_acc;
   logic                      found;
   int                        cand;

   logic                      sel_tvalid, sel_tfirst, sel_tlast;
   logic [DATA_WIDTH-1:0]     sel_tdata;
   logic [KEEP_WIDTH-1:0]     sel_tkeep;

   // Select the granted channel's stream lanes
   always_comb begin
      sel_tvalid = 1'b0;
      sel_tfirst = 1'b0;
      sel_tlast  = 1'b0;
      sel_tdata  = '0;
      sel_tkeep  = '0;
      for (int i = 0; i < N; i++) begin
         if (grant_q == CW'(i)) begin
            sel_tvalid = s_if.tvalid[i];
            sel_tfirst = s_if.tfirst[i];
            sel_tlast  = s_if.tlast[i];
            sel_tdata  = s_if.tdata[i*DATA_WIDTH +: DATA_WIDTH];
            sel_tkeep  = s_if.tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
         end
      end
   end

   // Arbitration FSM: next state, captured metadata, readies and framing flags
   always_comb begin
      state_d        = state_q;
      rr_d           = rr_q;
      grant_d        = grant_q;
      ip_d           = ip_q;
      dst_d          = dst_q;
      src_d          = src_q;
      len_d          = len_q;
      first_d        = first_q;
      err_d          = err_q;
      meta_ready     = '0;
      data_ready     = '0;
      out_meta_valid = 1'b0;
      out_tvalid     = 1'b0;
      beat_acc       = 1'b0;
      found          = 1'b0;
      cand           = 0;
      case (state_q)
         ST_IDLE: begin
            // Readies stay low while reset is held, even though state is already IDLE
            if (reset_n) begin
               for (int off = 0; off < N; off++) begin
                  cand = int'(rr_q) + off;
                  if (cand >= N) cand = cand - N;
                  for (int i = 0; i < N; i++) begin
                     if (!found && (i == cand) && s_if.meta_valid[i]) begin
                        found         = 1'b1;
                        meta_ready[i] = 1'b1;
                        grant_d       = CW'(i);
                        ip_d  = s_if.meta_ip_addr[i*IP_ADDR_WIDTH +: IP_ADDR_WIDTH];
                        dst_d = s_if.meta_dst_port[i*UDP_PORT_WIDTH +: UDP_PORT_WIDTH];
                        src_d = s_if.meta_src_port[i*UDP_PORT_WIDTH +: UDP_PORT_WIDTH];
                        len_d = s_if.meta_data_len[i*UDP_LEN_WIDTH +: UDP_LEN_WIDTH];
                     end
                  end
               end
               if (found) begin
                  state_d = ST_META;
                  first_d = 1'b1;
               end
            end
         end
         ST_META: begin
            out_meta_valid = 1'b1;
            if (m_if.meta_ready[0]) state_d = ST_DATA;
         end
         ST_DATA: begin
            out_tvalid = sel_tvalid;
            beat_acc   = sel_tvalid & m_if.tready[0];
            for (int i = 0; i < N; i++) begin
               if (grant_q == CW'(i)) begin
                  data_ready[i] = m_if.tready[0];
                  // Only the opening beat may carry tfirst
                  if (beat_acc && (first_q != sel_tfirst)) err_d[i] = 1'b1;
               end
            end
            if (beat_acc) begin
               first_d = 1'b0;
               if (sel_tlast) begin
                  state_d = ST_IDLE;
                  rr_d    = (grant_q == CW'(N - 1)) ? '0 : grant_q + 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and metadata registers, cleared asynchronously
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         rr_q    <= '0;
         grant_q <= '0;
         ip_q    <= '0;
         dst_q   <= '0;
         src_q   <= '0;
         len_q   <= '0;
         first_q <= 1'b0;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         grant_q <= grant_d;
         ip_q    <= ip_d;
         dst_q   <= dst_d;
         src_q   <= src_d;
         len_q   <= len_d;
         first_q <= first_d;
         err_q   <= err_d;
      end
   end

   assign s_if.meta_ready    = meta_ready;
   assign s_if.tready        = data_ready;
   assign m_if.meta_valid    = out_meta_valid;
   assign m_if.meta_ip_addr  = ip_q;
   assign m_if.meta_dst_port = dst_q;
   assign m_if.meta_src_port = src_q;
   assign m_if.meta_data_len = len_q;
   assign m_if.tvalid        = out_tvalid;
   assign m_if.tdata         = (state_q == ST_DATA) ? sel_tdata  : '0;
   assign m_if.tkeep         = (state_q == ST_DATA) ? sel_tkeep  : '0;
   assign m_if.tfirst        = (state_q == ST_DATA) ? sel_tfirst : 1'b0;
   assign m_if.tlast         = (state_q == ST_DATA) ? sel_tlast  : 1'b0;
   assign m_grant_chan       = grant_q;
   assign busy               = (state_q != ST_IDLE);
   assign err_framing        = err_q;
endmodule

// File: doc/udp_tx_channel_arbiter.md
UDP_TX_CHANNEL_ARBITER -- requirements
Module: udp_tx_channel_arbiter

Interface
REQ-001 Parameter NUM_CHANNELS, default 4: number of independent TX client channels; legal range 1..16.
REQ-002 Parameter DATA_WIDTH, default 256: data stream beat width in bits.
REQ-003 Parameter KEEP_WIDTH, default 32: byte-enable width, equal to DATA_WIDTH/8.
REQ-004 Parameters IP_ADDR_WIDTH 32, UDP_PORT_WIDTH 16, UDP_LEN_WIDTH 16: metadata field widths.
REQ-005 CW = max(1, clog2(NUM_CHANNELS)) is derived and is not a user parameter.
REQ-006 Port clk, input, 1: the single clock; all logic is rising-edge.
REQ-007 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-008 Ports s_udp_meta_valid/ready, 1 bit per channel each (input/output): per-channel metadata handshake.
REQ-009 Ports s_udp_meta_ip_addr, dst_port, src_port, data_len, input, NUM_CHANNELS x field width, packed with channel 0 in the LSBs: per-channel metadata.
REQ-010 Ports s_data_stream_tvalid/tready/tfirst/tlast, 1 bit per channel each (tready is output, the rest input): per-channel stream control.
REQ-011 Ports s_data_stream_tdata and tkeep, input, NUM_CHANNELS x DATA_WIDTH and NUM_CHANNELS x KEEP_WIDTH, packed: per-channel payload.
REQ-012 Ports m_udp_meta_valid (out), m_udp_meta_ready (in), m_udp_meta_ip_addr/dst_port/src_port/data_len (out): merged metadata toward the UDP TX core.
REQ-013 Ports m_data_stream_tvalid/tdata/tkeep/tfirst/tlast (out) and m_data_stream_tready (in): merged data stream toward the UDP TX core.
REQ-014 Port m_grant_chan, output, CW: index of the channel currently owning the output.
REQ-015 Port busy, output, 1: high in every state except IDLE.
REQ-016 Port err_framing, output, NUM_CHANNELS: sticky per-channel framing error flags.

Function
REQ-017 The block is a three-state FSM: IDLE, META, DATA.
REQ-018 In IDLE with no s_udp_meta_valid asserted, the FSM stays in IDLE and all s_*_ready outputs are 0.
REQ-019 In IDLE, the grant goes to the first channel with s_udp_meta_valid=1, searching upward from rr_ptr and wrapping from NUM_CHANNELS-1 to 0.
REQ-020 In the grant cycle, s_udp_meta_ready is 1 for the granted channel only, its metadata is captured into a register, m_grant_chan is loaded, and the FSM moves to META.
REQ-021 In META, m_udp_meta_valid=1 and the m_udp_meta_* outputs come from the register and are held stable until m_udp_meta_ready=1; on that handshake the FSM moves to DATA.
REQ-022 In DATA, the granted channel's stream passes through combinationally (tvalid, tdata, tkeep, tfirst, tlast forward; s_data_stream_tready[g] = m_data_stream_tready).
REQ-023 In DATA, s_data_stream_tready for non-granted channels is 0, and m_data_stream_tvalid is 0 whenever the FSM is not in DATA.
REQ-024 A beat with tvalid&tready&tlast ends the packet: the FSM moves to IDLE and rr_ptr becomes (g+1) mod NUM_CHANNELS.
REQ-025 The minimum cost per packet is 1 IDLE cycle plus 1 META cycle plus the data beats, so a new grant cannot start in the cycle the tlast handshake completes.
REQ-026 A channel's data is never accepted before its metadata has been granted: data stalls while meta is still pending.
REQ-027 The data_len field is forwarded unmodified and is not checked against the beat count.
REQ-028 err_framing[g] is set on an accepted beat if either: it is the first beat of the packet and tfirst=0; or it is a later beat and tfirst=1.
REQ-029 err_framing bits are sticky and are not cleared by any event other than reset.
REQ-030 With NUM_CHANNELS=1, m_grant_chan is constantly 0 and the FSM behaviour is otherwise unchanged.
REQ-031 Requests arriving on other channels during META or DATA wait without being dropped, since their ready stays 0.
REQ-032 A valid that deasserts before its grant is legal and is ignored.

Reset
REQ-033 Asserting reset_n=0 at any time, including mid-packet, forces within the same cycle: state IDLE, rr_ptr 0, m_grant_chan 0, err_framing 0, metadata register 0.
REQ-034 During reset, all valid and ready outputs are 0 and busy is 0.
REQ-035 A packet cut off by reset is abandoned, and the block does not resume it after reset.
REQ-036 Deassertion of reset is synchronised externally; the first grant can occur on the first clock edge after release.

Verification
REQ-037 Single packet: channel 0 gives meta(ip=0x0A000002, dst=4791, src=4791, len=64) and 2 beats (tfirst on beat 0, tlast on beat 1), sink always ready -> meta emitted exactly once, 2 output beats, m_grant_chan=0, err_framing=0.
REQ-038 Round-robin: all 4 channels request continuously with 1-beat packets -> grant order 0,1,2,3,0, and each packet takes 3 cycles.
REQ-039 Backpressure: m_data_stream_tready toggles every cycle during a 4-beat packet -> tdata is stable while stalled, no beat is lost or duplicated, and other channels see tready=0.
REQ-040 Framing: channel 2 sends its first beat with tfirst=0 -> err_framing=4'b0100, and the bit stays set over later packets.
REQ-041 Reset mid-packet: reset_n pulsed low on beat 1 of a 3-beat packet -> outputs drop at once, state IDLE, rr_ptr=0, and the next grant goes to the lowest requesting channel.
